// File: rtl/syscall_pkg.sv
// Shared codes, register indices, ASCII constants and FSM states for the syscall service unit.
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHR = 32'd11;

    localparam logic [4:0] REG_V0 = 5'd2;
    localparam logic [4:0] REG_A0 = 5'd4;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_V0,
        S_RD_A0,
        S_DISPATCH,
        S_INT_CONV,
        S_INT_EMIT,
        S_STR_FETCH,
        S_STR_WAIT,
        S_STR_EMIT,
        S_CHR_EMIT,
        S_DONE
    } state_t;

    // Two's-complement magnitude; 32'h8000_0000 maps to unsigned 2147483648.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: 32-bit unsigned to 10 BCD digits in exactly 32 shift-add-3 steps.
module bin_to_bcd_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [39:0] bcd_o
);

    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [39:0] adj;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                                : bcd_q[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done_o marks the cycle whose closing edge performs the final step; bcd_o is valid after it.
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == 5'd31);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/syscall_service_unit.sv
// Services print-int/print-string/print-char/exit once the drained pipeline raises SYSCALL_REQ,
// streaming bytes to a ready/valid console and pulsing SYSCALL_DONE when finished.
module syscall_service_unit
    import syscall_pkg::*;
#(
    parameter int MAX_STR_LEN = 256,
    parameter bit INT_NEWLINE = 1'b0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        SYSCALL_REQ,
    output logic        SYSCALL_DONE,
    output logic [4:0]  REG_RADDR,
    input  logic [31:0] REG_RDATA,
    output logic        MEM_RE,
    output logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_RVALID,
    output logic [7:0]  CON_DATA,
    output logic        CON_VALID,
    input  logic        CON_READY,
    output logic        HALT,
    output logic        ERR_UNSUPPORTED
);

    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    state_t             state_q, state_d;
    logic               req_prev_q;
    logic               halt_q, halt_d;
    logic               err_q, err_d;
    logic [31:0]        v0_q, v0_d;
    logic [7:0]         chr_q, chr_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [31:0]        word_q, word_d;
    logic               sign_q, sign_d;
    logic [3:0]         dig_q, dig_d;
    logic               dig_ok_q, dig_ok_d;
    logic               lf_q, lf_d;

    logic               bcd_start, bcd_busy, bcd_done;
    logic [39:0]        bcd;
    logic [9:0]         dig_nz;
    logic [3:0]         msd, cur_dig, digit;
    logic [7:0]         str_byte;

    bin_to_bcd_seq u_bcd (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .start_i (bcd_start),
        .bin_i   (magnitude(REG_RDATA)),
        .busy_o  (bcd_busy),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_nz
            assign dig_nz[gi] = |bcd[4*gi +: 4];
        end
    endgenerate

    // Most significant non-zero digit; zero value falls back to digit 0 so '0' is printed.
    always_comb begin
        msd = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (dig_nz[i]) begin
                msd = 4'(i);
            end
        end
    end

    assign cur_dig   = dig_ok_q ? dig_q : msd;
    assign digit     = bcd[{cur_dig, 2'b00} +: 4];
    assign str_byte  = word_q[{ptr_q[1:0], 3'b000} +: 8];
    assign cnt_inc   = cnt_q + 1'b1;
    assign bcd_start = (state_q == S_DISPATCH) && (v0_q == SYS_PRINT_INT) && !bcd_busy;

    always_comb begin
        state_d         = state_q;
        halt_d          = halt_q;
        err_d           = err_q;
        v0_d            = v0_q;
        chr_d           = chr_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        word_d          = word_q;
        sign_d          = sign_q;
        dig_d           = dig_q;
        dig_ok_d        = dig_ok_q;
        lf_d            = lf_q;
        SYSCALL_DONE    = 1'b0;
        ERR_UNSUPPORTED = 1'b0;
        REG_RADDR       = 5'd0;
        MEM_RE          = 1'b0;
        MEM_ADDR        = 32'd0;
        CON_DATA        = 8'd0;
        CON_VALID       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Rising-edge qualified so a request still held after DONE is not serviced twice.
                if (SYSCALL_REQ && !req_prev_q && !halt_q) begin
                    state_d = S_RD_V0;
                end
            end
            S_RD_V0: begin
                REG_RADDR = REG_V0;
                state_d   = S_RD_A0;
            end
            S_RD_A0: begin
                REG_RADDR = REG_A0;
                v0_d      = REG_RDATA;
                state_d   = S_DISPATCH;
            end
            S_DISPATCH: begin
                chr_d    = REG_RDATA[7:0];
                ptr_d    = REG_RDATA;
                sign_d   = REG_RDATA[31];
                cnt_d    = '0;
                dig_ok_d = 1'b0;
                lf_d     = 1'b0;
                err_d    = 1'b0;
                case (v0_q)
                    SYS_PRINT_INT: state_d = S_INT_CONV;
                    SYS_PRINT_STR: state_d = S_STR_FETCH;
                    SYS_PRINT_CHR: state_d = S_CHR_EMIT;
                    SYS_EXIT: begin
                        halt_d  = 1'b1;
                        state_d = S_DONE;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_INT_CONV: begin
                if (bcd_done) begin
                    state_d = S_INT_EMIT;
                end
            end
            S_INT_EMIT: begin
                CON_VALID = 1'b1;
                if (sign_q) begin
                    CON_DATA = ASCII_MINUS;
                    if (CON_READY) begin
                        sign_d   = 1'b0;
                        dig_d    = msd;
                        dig_ok_d = 1'b1;
                    end
                end else if (lf_q) begin
                    CON_DATA = ASCII_LF;
                    if (CON_READY) begin
                        state_d = S_DONE;
                    end
                end else begin
                    CON_DATA = ASCII_0 + {4'd0, digit};
                    if (CON_READY) begin
                        if (cur_dig == 4'd0) begin
                            if (INT_NEWLINE) begin
                                lf_d = 1'b1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            dig_d    = cur_dig - 4'd1;
                            dig_ok_d = 1'b1;
                        end
                    end
                end
            end
            S_STR_FETCH: begin
                MEM_RE   = 1'b1;
                MEM_ADDR = {ptr_q[31:2], 2'b00};
                state_d  = S_STR_WAIT;
            end
            S_STR_WAIT: begin
                MEM_RE   = 1'b1;
                MEM_ADDR = {ptr_q[31:2], 2'b00};
                if (MEM_RVALID) begin
                    word_d  = MEM_RDATA;
                    state_d = S_STR_EMIT;
                end
            end
            S_STR_EMIT: begin
                if (str_byte == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    CON_VALID = 1'b1;
                    CON_DATA  = str_byte;
                    if (CON_READY) begin
                        ptr_d = ptr_q + 32'd1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(MAX_STR_LEN)) begin
                            state_d = S_DONE;
                        end else if (ptr_q[1:0] == 2'd3) begin
                            state_d = S_STR_FETCH;
                        end
                    end
                end
            end
            S_CHR_EMIT: begin
                CON_VALID = 1'b1;
                CON_DATA  = chr_q;
                if (CON_READY) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                SYSCALL_DONE    = 1'b1;
                ERR_UNSUPPORTED = err_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            req_prev_q <= 1'b0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
            v0_q       <= '0;
            chr_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            sign_q     <= 1'b0;
            dig_q      <= '0;
            dig_ok_q   <= 1'b0;
            lf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= SYSCALL_REQ;
            halt_q     <= halt_d;
            err_q      <= err_d;
            v0_q       <= v0_d;
            chr_q      <= chr_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            sign_q     <= sign_d;
            dig_q      <= dig_d;
            dig_ok_q   <= dig_ok_d;
            lf_q       <= lf_d;
        end
    end

    assign HALT = halt_q;

endmodule

// File: tb/tb_syscall_service_unit.sv
// Bench for syscall_service_unit: table vectors, randomized calls vs. a string-level model, corner sequences.
module tb_syscall_service_unit;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        SYSCALL_REQ = 1'b0;
    logic        SYSCALL_DONE;
    logic [4:0]  REG_RADDR;
    logic [31:0] REG_RDATA = '0;
    logic        MEM_RE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_RVALID = 1'b0;
    logic [7:0]  CON_DATA;
    logic        CON_VALID;
    logic        CON_READY = 1'b0;
    logic        HALT;
    logic        ERR_UNSUPPORTED;

    syscall_service_unit dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .SYSCALL_REQ     (SYSCALL_REQ),
        .SYSCALL_DONE    (SYSCALL_DONE),
        .REG_RADDR       (REG_RADDR),
        .REG_RDATA       (REG_RDATA),
        .MEM_RE          (MEM_RE),
        .MEM_ADDR        (MEM_ADDR),
        .MEM_RDATA       (MEM_RDATA),
        .MEM_RVALID      (MEM_RVALID),
        .CON_DATA        (CON_DATA),
        .CON_VALID       (CON_VALID),
        .CON_READY       (CON_READY),
        .HALT            (HALT),
        .ERR_UNSUPPORTED (ERR_UNSUPPORTED)
    );

    always #5 CLOCK = ~CLOCK;

    localparam int BUDGET = 3000;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] a0;
        int          rmode;
        int          lat;
        int          exp_first;
        string       exp_s;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[14];
    int          vec_n = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          mem_lat = 1;
    int          done_cnt, err_cnt, first_valid, done_cyc, req_cyc;
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    bit          exp_err, exp_halt;
    logic [31:0] regs[32];
    logic [31:0] mem_w[1024];
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [9:0]  mem_idx = '0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_n++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        return {14'd0, SYSCALL_DONE, REG_RADDR, MEM_RE, MEM_ADDR, CON_DATA, CON_VALID, HALT, ERR_UNSUPPORTED};
    endfunction

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Register file with one-cycle read latency.
    always @(posedge CLOCK) REG_RDATA <= regs[REG_RADDR];

    // Word memory answering each read strobe after mem_lat cycles; unaffected by the DUT reset.
    always @(posedge CLOCK) begin
        if (MEM_RVALID) begin
            MEM_RVALID <= 1'b0;
            mem_busy   <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                MEM_RVALID <= 1'b1;
                MEM_RDATA  <= mem_w[mem_idx];
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (MEM_RE) begin
            mem_busy <= 1'b1;
            mem_idx  <= MEM_ADDR[11:2];
            if (mem_lat <= 1) begin
                MEM_RVALID <= 1'b1;
                MEM_RDATA  <= mem_w[MEM_ADDR[11:2]];
            end else begin
                mem_cnt <= mem_lat - 2;
            end
        end
    end

    // Console sink and output monitor, evaluated on the falling edge.
    always @(negedge CLOCK) begin
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("con_hold_valid", {63'd0, CON_VALID}, 64'd1);
                chk("con_hold_data", {56'd0, CON_DATA}, {56'd0, prev_data});
            end
            case (ready_mode)
                0:       CON_READY = 1'b1;
                1:       CON_READY = !CON_READY;
                2:       CON_READY = 1'($urandom_range(0, 1));
                default: CON_READY = 1'b0;
            endcase
            if (CON_VALID && CON_READY) cap_q.push_back(CON_DATA);
            prev_stall = CON_VALID && !CON_READY;
            prev_data  = CON_DATA;
            if (CON_VALID && first_valid < 0) first_valid = cyc;
            if (SYSCALL_DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (ERR_UNSUPPORTED) begin
                err_cnt++;
                chk("err_with_done", {63'd0, SYSCALL_DONE}, 64'd1);
            end
            if (MEM_RE) chk("mem_addr_align", {62'd0, MEM_ADDR[1:0]}, 64'd0);
        end
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] addr);
        logic [31:0] w;
        w = mem_w[addr[11:2]];
        return w[8*addr[1:0] +: 8];
    endfunction

    // Expected console stream and flags derived from the syscall semantics.
    task automatic ref_model(input logic [31:0] v0, input logic [31:0] a0);
        string s;
        logic [31:0] addr;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_halt = 1'b0;
        case (v0)
            32'd1: begin
                s = $sformatf("%0d", $signed(a0));
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            end
            32'd4: begin
                addr = a0;
                while (exp_q.size() < 256 && mem_byte(addr) != 8'd0) begin
                    exp_q.push_back(mem_byte(addr));
                    addr++;
                end
            end
            32'd11:  exp_q.push_back(a0[7:0]);
            32'd10:  exp_halt = 1'b1;
            default: exp_err = 1'b1;
        endcase
    endtask

    task automatic do_call(input logic [31:0] v0, input logic [31:0] a0, input int rmode, input int lat);
        regs[2]     = v0;
        regs[4]     = a0;
        ready_mode  = rmode;
        mem_lat     = lat;
        cap_q.delete();
        done_cnt    = 0;
        err_cnt     = 0;
        first_valid = -1;
        done_cyc    = -1;
        SYSCALL_REQ = 1'b1;
        req_cyc     = cyc + 1;
        for (int i = 0; i < BUDGET && done_cnt == 0; i++) tick();
        tick();
        SYSCALL_REQ = 1'b0;
        repeat (6) tick();
    endtask

    task automatic check_call(input string tag);
        int bad;
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_err"}, 64'(err_cnt), {63'd0, exp_err});
        chk({tag, "_halt"}, {63'd0, HALT}, {63'd0, exp_halt});
        chk({tag, "_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
        bad = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i] && bad < 0) bad = i;
        vec_n++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s_bytes: byte %0d got %02h, expected %02h", tag, bad, cap_q[bad], exp_q[bad]);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] v0, input logic [31:0] a0, input int rmode,
                           input int lat, input int first, input string s, input bit err);
        tbl[i].v0 = v0; tbl[i].a0 = a0; tbl[i].rmode = rmode; tbl[i].lat = lat;
        tbl[i].exp_first = first; tbl[i].exp_s = s; tbl[i].exp_err = err;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string xs;
        logic [31:0] v0, a0;
        xs = "";
        for (int i = 0; i < 256; i++) xs = {xs, "x"};
        set_vec(0,  32'd1,  32'hFFFF_FF85,   0, 1, 35, "-123", 1'b0);
        set_vec(1,  32'd1,  32'd0,           0, 1, 35, "0", 1'b0);
        set_vec(2,  32'd1,  32'h8000_0000,   0, 1, 35, "-2147483648", 1'b0);
        set_vec(3,  32'd1,  32'h7FFF_FFFF,   2, 1, -1, "2147483647", 1'b0);
        set_vec(4,  32'd1,  32'd1000000000,  1, 1, -1, "1000000000", 1'b0);
        set_vec(5,  32'd1,  32'd7,           0, 1, 35, "7", 1'b0);
        set_vec(6,  32'd4,  32'h0000_0102,   1, 3, -1, "Hi!", 1'b0);
        set_vec(7,  32'd11, 32'h0000_0041,   0, 1, 3,  "A", 1'b0);
        set_vec(8,  32'd11, 32'h1234_017A,   1, 1, 3,  "z", 1'b0);
        set_vec(9,  32'd99, 32'h0000_0102,   0, 1, -1, "", 1'b1);
        set_vec(10, 32'd0,  32'h0000_0000,   0, 1, -1, "", 1'b1);
        set_vec(11, 32'd4,  32'h0000_0300,   0, 2, -1, "", 1'b0);
        set_vec(12, 32'd4,  32'h0000_0401,   2, 2, -1, xs, 1'b0);
        set_vec(13, 32'd4,  32'h0000_0104,   0, 4, -1, "!", 1'b0);

        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        for (int i = 0; i < 1024; i++) mem_w[i] = 32'h0;
        mem_w[32'h100 >> 2] = 32'h6948_0000;
        mem_w[32'h104 >> 2] = 32'h0000_0021;
        for (int i = 32'h400 >> 2; i < (32'h800 >> 2); i++) mem_w[i] = 32'h7878_7878;
        for (int i = 32'h800; i < 32'h1000; i++)
            mem_w[i >> 2][8*(i % 4) +: 8] = ($urandom_range(0, 39) == 0) ? 8'd0 : 8'($urandom_range(1, 255));

        repeat (3) tick();
        chk("reset_outputs_in_reset", outs(), 64'd0);
        RESET = 1'b0;
        tick();
        chk("reset_outputs_after", outs(), 64'd0);

        for (int i = 0; i < 14; i++) begin
            exp_q.delete();
            for (int k = 0; k < tbl[i].exp_s.len(); k++) exp_q.push_back(tbl[i].exp_s[k]);
            exp_err  = tbl[i].exp_err;
            exp_halt = 1'b0;
            do_call(tbl[i].v0, tbl[i].a0, tbl[i].rmode, tbl[i].lat);
            check_call($sformatf("tbl%0d", i));
            if (tbl[i].exp_first >= 0)
                chk($sformatf("tbl%0d_first_valid_lat", i), 64'(first_valid - req_cyc), 64'(tbl[i].exp_first));
        end

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    v0 = 32'd1;
                    a0 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 99999));
                    if ($urandom_range(0, 1) == 1) a0 = -a0;
                end
                4, 5, 6: begin
                    v0 = 32'd4;
                    a0 = 32'h800 + 32'($urandom_range(0, 32'h5FF));
                end
                7, 8: begin
                    v0 = 32'd11;
                    a0 = $urandom | 32'h1;
                end
                default: begin
                    v0 = 32'($urandom_range(12, 1000));
                    a0 = $urandom;
                end
            endcase
            ref_model(v0, a0);
            do_call(v0, a0, $urandom_range(0, 2), $urandom_range(1, 4));
            check_call($sformatf("rnd%0d_v0_%0d", n, v0));
        end

        // exit: DONE three cycles after the sampling edge, HALT sticky, later requests ignored
        ref_model(32'd10, 32'd0);
        do_call(32'd10, 32'd0, 0, 1);
        check_call("exit");
        chk("exit_done_lat", 64'(done_cyc - req_cyc), 64'd3);
        done_cnt    = 0;
        SYSCALL_REQ = 1'b1;
        repeat (10) tick();
        SYSCALL_REQ = 1'b0;
        tick();
        chk("halted_req_ignored", 64'(done_cnt), 64'd0);
        chk("halt_sticky", {63'd0, HALT}, 64'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        chk("halt_cleared_by_reset", {63'd0, HALT}, 64'd0);

        // reset while a byte is offered and the console stalls
        regs[2] = 32'd4; regs[4] = 32'h400; ready_mode = 3; mem_lat = 1;
        SYSCALL_REQ = 1'b1;
        for (int i = 0; i < 50 && !CON_VALID; i++) tick();
        chk("emit_reached", {63'd0, CON_VALID}, 64'd1);
        RESET = 1'b1;
        tick();
        chk("reset_mid_emit_outputs", outs(), 64'd0);
        RESET = 1'b0;
        SYSCALL_REQ = 1'b0;
        tick();

        // reset while a memory read is outstanding; the late MEM_RVALID lands in IDLE
        regs[4] = 32'h400; ready_mode = 0; mem_lat = 4;
        SYSCALL_REQ = 1'b1;
        for (int i = 0; i < 50 && !MEM_RE; i++) tick();
        chk("fetch_reached", {63'd0, MEM_RE}, 64'd1);
        RESET = 1'b1;
        SYSCALL_REQ = 1'b0;
        tick();
        RESET = 1'b0;
        done_cnt = 0;
        cap_q.delete();
        repeat (8) tick();
        chk("stale_rvalid_no_done", 64'(done_cnt), 64'd0);
        chk("stale_rvalid_no_bytes", 64'(cap_q.size()), 64'd0);
        chk("stale_rvalid_outputs", outs(), 64'd0);
        ref_model(32'd4, 32'h102);
        do_call(32'd4, 32'h102, 2, 3);
        check_call("after_reset_str");

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miscompares);
        $finish;
    end

endmodule
